// File: rtl/stream_sort_n.sv
// Frame sorter: buffers DEPTH samples, runs DEPTH odd-even transposition passes, then holds the sorted frame.
// Define STREAM_SORT_DESCEND_EN to sort descending (slot 0 largest); default build sorts ascending.
module stream_sort_n #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH*DEPTH-1:0] out_data,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int            CW   = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_load;
  logic [CW-1:0]   r_pass;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_out_valid;
  logic [WIDTH-1:0] r_slot [DEPTH];
  logic [WIDTH-1:0] w_next [DEPTH];

  function automatic logic out_of_order(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef STREAM_SORT_DESCEND_EN
    return a < b;
`else
    return a > b;
`endif
  endfunction

  // One transposition pass: pairs start on even slots for even passes, odd slots for odd passes.
  always_comb begin
    // NOTE: default the whole array first so no path leaves an element unassigned (no latch).
    w_next = r_slot;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if ((i[0] == r_pass[0]) && out_of_order(r_slot[i], r_slot[i+1])) begin
        w_next[i]   = r_slot[i+1];
        w_next[i+1] = r_slot[i];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      out_data[WIDTH*(DEPTH-k)-1 -: WIDTH] = r_slot[k];
    end
  end

  // NOTE: state registers use <= only, so every read in this block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= LOAD;
      r_load      <= '0;
      r_pass      <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      // NOTE: slot storage is cleared on reset so out_data is defined after any reset.
      for (int k = 0; k < DEPTH; k++) begin
        r_slot[k] <= '0;
      end
    end else begin
      case (r_state)
        LOAD: begin
          if (in_valid && r_in_ready) begin
            r_slot[r_load] <= in_data;
            if (r_load == LAST) begin
              r_load     <= '0;
              r_state    <= SORT;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_load <= r_load + CW'(1);
            end
          end
        end
        SORT: begin
          r_slot <= w_next;
          if (r_pass == LAST) begin
            r_pass      <= '0;
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_pass <= r_pass + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= LOAD;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= LOAD;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_sort_n.sv
// Scoreboard bench for stream_sort_n: a 4x8 instance with directed frames and an 8x4 instance with
// random frames checked against a reference sort; expectations follow STREAM_SORT_DESCEND_EN.
module tb_stream_sort_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [7:0]  a_in_data;
  logic [31:0] a_out_data;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [3:0]  b_in_data;
  logic [31:0] b_out_data;

  stream_sort_n #(.WIDTH(8), .DEPTH(4)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .busy(a_busy)
  );

  stream_sort_n #(.WIDTH(4), .DEPTH(8)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .busy(b_busy)
  );

`ifdef STREAM_SORT_DESCEND_EN
  localparam logic [31:0] E1 = 32'h09070301, E2 = 32'hFF050500, E3 = 32'h07070707;
  localparam logic [31:0] E4 = 32'hFFFF0000, E5 = 32'h40302010, E6 = 32'h08060402;
`else
  localparam logic [31:0] E1 = 32'h01030709, E2 = 32'h000505FF, E3 = 32'h07070707;
  localparam logic [31:0] E4 = 32'h0000FFFF, E5 = 32'h10203040, E6 = 32'h02040608;
`endif

  typedef struct {
    logic [31:0] data;
    int          rise;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   edge_n   = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired or unexpected event (edge %0d)", name, edge_n);
  endtask

  function automatic logic [31:0] ref_sort8(input logic [31:0] f);
    logic [3:0]  v [8];
    logic [3:0]  t;
    logic [31:0] r;
    for (int k = 0; k < 8; k++) v[k] = f[31-4*k -: 4];
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 7; j++) begin
`ifdef STREAM_SORT_DESCEND_EN
        if (v[j] < v[j+1]) begin
`else
        if (v[j] > v[j+1]) begin
`endif
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    r = '0;
    for (int k = 0; k < 8; k++) r[31-4*k -: 4] = v[k];
    return r;
  endfunction

  // Monitor A: latency, hold stability, in_ready gating and frame contents.
  logic        a_prev_valid = 1'b0;
  logic [31:0] a_held;
  int          a_rise = 0;
  exp_t        a_e;
  always begin
    @(negedge clk);
    #1;
    if (reset !== 1'b1) begin
      a_prev_valid = 1'b0;
    end else begin
      if (a_out_valid && !a_prev_valid) a_rise = edge_n;
      if (a_out_valid && a_prev_valid) check("a_hold_stable", a_out_data, a_held);
      if (a_out_valid || a_busy) check("a_in_ready_low", a_in_ready, 1'b0);
      if (a_out_valid && a_out_ready) begin
        if (q_a.size() == 0) fail_now("a_unexpected_frame");
        else begin
          a_e = q_a.pop_front();
          check("a_frame_data", a_out_data, a_e.data);
          check("a_latency", a_rise, a_e.rise);
        end
      end
      a_held       = a_out_data;
      a_prev_valid = a_out_valid;
    end
  end

  logic b_prev_valid = 1'b0;
  int   b_rise = 0;
  exp_t b_e;
  always begin
    @(negedge clk);
    #1;
    if (reset !== 1'b1) begin
      b_prev_valid = 1'b0;
    end else begin
      if (b_out_valid && !b_prev_valid) b_rise = edge_n;
      if (b_out_valid && b_out_ready) begin
        if (q_b.size() == 0) fail_now("b_unexpected_frame");
        else begin
          b_e = q_b.pop_front();
          check("b_frame_data", b_out_data, b_e.data);
          check("b_latency", b_rise, b_e.rise);
        end
      end
      b_prev_valid = b_out_valid;
    end
  end

  task automatic send_a(input logic [31:0] smp, input logic [31:0] exp, input int gap, input bit push);
    for (int k = 0; k < 4; k++) begin
      int waited = 0;
      a_in_valid = 1'b1;
      a_in_data  = smp[31-8*k -: 8];
      while (a_in_ready !== 1'b1 && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 100) begin
        fail_now("a_in_ready_timeout");
        a_in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      a_in_valid = 1'b0;
      if (k < 3) repeat (gap) @(negedge clk);
    end
    if (push) q_a.push_back('{exp, edge_n + 4});
    check("a_busy_in_sort", a_busy, 1'b1);
    check("a_in_ready_in_sort", a_in_ready, 1'b0);
  endtask

  task automatic send_b(input logic [31:0] smp);
    for (int k = 0; k < 8; k++) begin
      int waited = 0;
      b_in_valid = 1'b1;
      b_in_data  = smp[31-4*k -: 4];
      while (b_in_ready !== 1'b1 && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 100) begin
        fail_now("b_in_ready_timeout");
        b_in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      b_in_valid = 1'b0;
    end
    q_b.push_back('{ref_sort8(smp), edge_n + 8});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
  endtask

  initial begin
    int n;
    logic [31:0] f;
    reset = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_busy", a_busy, 1'b0);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_data", a_out_data, 32'h0);
    check("rst_b_in_ready", b_in_ready, 1'b1);
    reset = 1'b1;
    @(negedge clk);

    send_a(32'h09030701, E1, 0, 1'b1);
    drain(40);
    send_a(32'h050500FF, E2, 1, 1'b1);
    drain(40);
    send_a(32'h07070707, E3, 0, 1'b1);
    send_a(32'hFF00FF00, E4, 2, 1'b1);
    drain(40);

    // Hold the finished frame while a sample is offered; nothing may be accepted.
    a_out_ready = 1'b0;
    send_a(32'h40302010, E5, 0, 1'b1);
    n = 0;
    while (a_out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (a_out_valid !== 1'b1) fail_now("a_wait_out_valid");
    a_in_valid = 1'b1;
    a_in_data  = 8'hAA;
    repeat (10) begin
      @(negedge clk);
      check("hold_in_ready", a_in_ready, 1'b0);
      check("hold_out_valid", a_out_valid, 1'b1);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", a_out_valid, 1'b0);
    check("release_in_ready", a_in_ready, 1'b1);
    a_in_valid = 1'b0;
    drain(10);

    // Partial frame discarded by reset.
    a_in_valid = 1'b1; a_in_data = 8'hAA;
    @(negedge clk);
    a_in_data = 8'hBB;
    @(negedge clk);
    a_in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midload_rst_in_ready", a_in_ready, 1'b1);
    check("midload_rst_busy", a_busy, 1'b0);
    send_a(32'h04020806, E6, 0, 1'b1);
    drain(40);

    // Reset during SORT: that frame must never appear.
    send_a(32'h11223344, 32'h0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midsort_rst_busy", a_busy, 1'b0);
    check("midsort_rst_in_ready", a_in_ready, 1'b1);
    check("midsort_rst_out_valid", a_out_valid, 1'b0);
    check("midsort_rst_out_data", a_out_data, 32'h0);
    repeat (8) @(negedge clk);
    check("midsort_no_frame", a_out_valid, 1'b0);
    send_a(32'h09030701, E1, 0, 1'b1);
    drain(40);

    for (int i = 0; i < 6; i++) begin
      f = $urandom;
      if (i == 0) f = 32'h3A3A0F10;
      send_b(f);
    end
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_sort_n.md
STREAM_SORT_N -- requirements
Module: stream_sort_n

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, samples per frame; even, >=2.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low; clock clk.
REQ-005 in_valid  input  1  in_data carries a sample.
REQ-006 in_data  input  WIDTH  unsigned sample.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 out_valid  output  1  out_data holds a sorted frame.
REQ-009 out_data  output  WIDTH*DEPTH  sorted frame; slot 0 in MSBs [WIDTH*DEPTH-1 -: WIDTH], slot DEPTH-1 in LSBs.
REQ-010 out_ready  input  1  consumer takes the frame this cycle.
REQ-011 busy  output  1  high in SORT state.

Function
REQ-012 FSM states LOAD, SORT, DONE; storage of DEPTH WIDTH-bit registers slot[0..DEPTH-1]; load counter 0..DEPTH-1; pass counter 0..DEPTH-1.
REQ-013 LOAD: in_ready=1; on in_valid&in_ready, in_data written to slot[load counter], counter increments; no write when in_valid=0 (gaps allowed).
REQ-014 LOAD->SORT on acceptance of sample DEPTH-1; load counter wraps to 0.
REQ-015 SORT: in_ready=0, busy=1; one odd-even transposition pass per cycle, exactly DEPTH passes.
REQ-016 Pass p even: compare/exchange pairs (0,1),(2,3),...; pass p odd: pairs (1,2),(3,4),...,(DEPTH-3,DEPTH-2).
REQ-017 Compare unsigned full WIDTH; swap only if slot[i] > slot[i+1] (ascending); equal values never swapped.
REQ-018 SORT->DONE after pass DEPTH-1; pass counter wraps to 0.
REQ-019 Latency: last sample accepted at edge t -> passes at edges t+1..t+DEPTH -> out_valid=1 from edge t+DEPTH.
REQ-020 DONE: out_valid=1, in_ready=0, out_data stable; held indefinitely while out_ready=0.
REQ-021 DONE->LOAD on out_valid&out_ready; first sample of next frame acceptable the cycle after.
REQ-022 out_data continuously reflects slot registers; meaningful only when out_valid=1.
REQ-023 in_valid ignored outside LOAD; no sample lost or stored when in_ready=0.

Reset
REQ-024 reset=0 at a rising edge: state LOAD, both counters 0, all slots 0, out_valid=0, busy=0, in_ready=1 after the edge.
REQ-025 Reset in any state (mid-load, mid-sort, DONE) discards the partial/held frame; reset has priority over all other activity.

Configuration
REQ-026 Macro STREAM_SORT_DESCEND_EN: defined -> swap iff slot[i] < slot[i+1] (slot 0 largest); undefined -> ascending per REQ-017; ports, latency, tie rule unchanged.

Verification
REQ-027 DEPTH=4,WIDTH=8, inputs 9,3,7,1 back-to-back -> out_valid exactly 4 cycles after last accept, out_data=0x01030709.
REQ-028 Inputs 5,5,0,255 with one-cycle in_valid gaps -> out_data=0x000505FF; in_ready=0 throughout SORT and DONE.
REQ-029 Frame done, out_ready=0 for 10 cycles, in_valid=1 -> out_data stable, no sample accepted; out_ready=1 -> out_valid=0, in_ready=1 next cycle.
REQ-030 Reset pulsed after 2 of 4 samples, then 4,2,8,6 -> out_data=0x02040608 (pre-reset samples discarded).
REQ-031 Reset pulsed during SORT -> out_valid never asserts for that frame, busy=0 and in_ready=1 after the edge.
REQ-032 STREAM_SORT_DESCEND_EN defined, inputs 9,3,7,1 -> out_data=0x09070301; DEPTH=8,WIDTH=4 random frames checked against a reference ascending sort.
